// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with load-use hazard detection
// and EX/MEM, MEM/WB operand forwarding for a 5-stage integer pipeline.
module ex_operand_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [2:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs_addr,
    input  logic [4:0]        id_rt_addr,
    input  logic [4:0]        id_rd_addr,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [4:0]        exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [4:0]        memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic [4:0]        ex_rd_addr,
    output logic              hazard_stall
);

    localparam logic [2:0] ALU_ADD = 3'b010;

    typedef struct packed {
        logic              valid;
        logic [2:0]        alu_op;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs_addr;
        logic [4:0]        rt_addr;
        logic [4:0]        rd_addr;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } idex_t;

    // A bubble is a harmless add of zeros with every control cleared.
    function automatic idex_t bubble();
        idex_t b;
        b        = '0;
        b.alu_op = ALU_ADD;
        return b;
    endfunction

    // Youngest writer wins; register 0 is hard-wired and never forwarded.
    function automatic logic [DATA_W-1:0] forward(input logic [4:0]        addr,
                                                  input logic [DATA_W-1:0] reg_data);
        logic [DATA_W-1:0] val;
        val = reg_data;
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == addr)
            val = exmem_result;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == addr)
            val = memwb_result;
        return val;
    endfunction

    idex_t             entry_q;
    idex_t             entry_d;
    idex_t             id_entry;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    // A load in EX whose destination is read by the instruction in ID cannot be
    // forwarded in time, so ID must wait one cycle behind an injected bubble.
    assign hazard_stall = entry_q.valid && entry_q.mem_read && (entry_q.rd_addr != 5'd0)
                        && id_valid
                        && (entry_q.rd_addr == id_rs_addr || entry_q.rd_addr == id_rt_addr);

    // Pack the ID inputs; an invalid ID slot loads as a bubble so it can never
    // raise a control output.
    always_comb begin
        // NOTE: the default first keeps every path assigned, so no latch is inferred.
        id_entry = bubble();
        if (id_valid) begin
            id_entry.valid      = 1'b1;
            id_entry.alu_op     = id_alu_op;
            id_entry.rs_data    = id_rs_data;
            id_entry.rt_data    = id_rt_data;
            id_entry.imm        = id_imm;
            id_entry.rs_addr    = id_rs_addr;
            id_entry.rt_addr    = id_rt_addr;
            id_entry.rd_addr    = id_rd_addr;
            id_entry.alu_src    = id_alu_src;
            id_entry.reg_write  = id_reg_write;
            id_entry.mem_read   = id_mem_read;
            id_entry.mem_write  = id_mem_write;
            id_entry.mem_to_reg = id_mem_to_reg;
        end
    end

    // Next-entry selection: flush beats stall beats load-use bubble beats load.
    always_comb begin
        entry_d = entry_q;
        if (flush)             entry_d = bubble();
        else if (stall)        entry_d = entry_q;
        else if (hazard_stall) entry_d = bubble();
        else                   entry_d = id_entry;
    end

    // ID/EX register; reset drops the held entry immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) entry_q <= bubble();
        else        entry_q <= entry_d;
    end

    // Operand forwarding and EX-facing outputs, all zero-latency from the register.
    always_comb begin
        rs_fwd        = forward(entry_q.rs_addr, entry_q.rs_data);
        rt_fwd        = forward(entry_q.rt_addr, entry_q.rt_data);
        alu_a         = rs_fwd;
        alu_b         = entry_q.alu_src ? entry_q.imm : rt_fwd;
        ex_store_data = rt_fwd;
        alu_op        = entry_q.alu_op;
        ex_valid      = entry_q.valid;
        ex_reg_write  = entry_q.reg_write;
        ex_mem_read   = entry_q.mem_read;
        ex_mem_write  = entry_q.mem_write;
        ex_mem_to_reg = entry_q.mem_to_reg;
        ex_rd_addr    = entry_q.rd_addr;
    end

endmodule
